inst_mem_responder: RTL and testbench

AXI4-style read responder that models the instruction memory behind the instruction cache's refill port. It accepts one read request at a time on the AR channel and returns `BEATS` 128-bit beats on the R channel after a programmable latency, honouring `RREADY` backpressure. A simple write port preloads program images. It sits at the far end of the cache refill interface and serves as both the simulation memory and the FPGA boot ROM.

---
 rtl/inst_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_inst_mem_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// inst_mem_responder: AXI4-style single-outstanding read responder backing the
// instruction-cache refill port. Returns BEATS x 128-bit beats after LATENCY
// idle cycles, honours RREADY backpressure, and has a preload write port.
module inst_mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned BEATS      = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [31:0]           ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [127:0]          RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [127:0]          wr_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DATA
  } state_e;

  logic [127:0] mem_q [DEPTH];

  state_e                state_q,   state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic                  rlast_q,   rlast_d;
  logic [127:0]          rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic [DEPTH_LOG2-1:0] idx_q,     idx_d;
  logic                  err_q,     err_d;
  logic [1:0]            beat_q,    beat_d;
  logic [3:0]            wait_q,    wait_d;

  logic [DEPTH_LOG2-1:0] ar_idx;
  logic                  ar_err;
  logic                  unused_addr_bits;

  logic                  ld_en;
  logic [DEPTH_LOG2-1:0] ld_idx;
  logic                  ld_err;
  logic [1:0]            ld_beat;
  logic [DEPTH_LOG2-1:0] ld_addr;

  assign ar_idx           = ARADDR[DEPTH_LOG2+3:4];
  assign ar_err           = |ARADDR[31:DEPTH_LOG2+4];
  assign unused_addr_bits = ^ARADDR[3:0];

  // Preload port: unreset storage, writable in every state.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Next-state logic; every beat load funnels through one shared array read
  // so the LATENCY=0 accept path, the WAIT exit and the next-beat path agree.
  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    idx_d     = idx_q;
    err_d     = err_q;
    beat_d    = beat_q;
    wait_d    = wait_q;
    ld_en     = 1'b0;
    ld_idx    = idx_q;
    ld_err    = err_q;
    ld_beat   = beat_q;

    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        if (ARVALID && arready_q) begin
          arready_d = 1'b0;
          idx_d     = ar_idx;
          err_d     = ar_err;
          beat_d    = 2'd0;
          if (LATENCY == 0) begin
            state_d  = S_DATA;
            rvalid_d = 1'b1;
            ld_en    = 1'b1;
            ld_idx   = ar_idx;
            ld_err   = ar_err;
            ld_beat  = 2'd0;
          end else begin
            state_d = S_WAIT;
            wait_d  = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        arready_d = 1'b0;
        if (wait_q == 4'd0) begin
          state_d  = S_DATA;
          rvalid_d = 1'b1;
          ld_en    = 1'b1;
          ld_beat  = 2'd0;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_DATA: begin
        if (RREADY) begin
          if (rlast_q) begin
            state_d   = S_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            beat_d  = beat_q + 2'd1;
            ld_en   = 1'b1;
            ld_beat = beat_q + 2'd1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
      end
    endcase

    ld_addr = ld_idx + DEPTH_LOG2'(ld_beat);
    if (ld_en) begin
      rdata_d = ld_err ? '0 : mem_q[ld_addr];
      rresp_d = ld_err ? 2'b10 : 2'b00;
      rlast_d = (ld_beat == 2'(BEATS - 1));
    end
  end

  // State and registered outputs; asynchronous reset abandons any burst.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      beat_q    <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Directed bench for inst_mem_responder: three instances sharing clock, reset
// and preload port (u0: LAT 2/BEATS 1, u1: LAT 0/BEATS 2, u2: LAT 1/BEATS 4).
module tb_inst_mem_responder;

  logic         clk;
  logic         resetn;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;

  logic [31:0]  araddr  [3];
  logic         arvalid [3];
  logic         arready [3];
  logic [127:0] rdata   [3];
  logic [1:0]   rresp   [3];
  logic         rlast   [3];
  logic         rvalid  [3];
  logic         rready  [3];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] E5  = 128'h00000013_00100093_00200113_00300193;
  localparam logic [127:0] E7  = 128'h77777777_00000007_DEADBEEF_01234567;
  localparam logic [127:0] E8  = 128'h88888888_00000008_CAFEF00D_89ABCDEF;
  localparam logic [127:0] E5N = 128'h0000006F_11111111_22222222_33333333;

  logic [127:0] wrapv [4];
  logic [9:0]   wrapi [4];

  inst_mem_responder #(.DEPTH_LOG2(10), .LATENCY(2), .BEATS(1)) u0 (
    .clk(clk), .resetn(resetn), .ARADDR(araddr[0]), .ARVALID(arvalid[0]),
    .ARREADY(arready[0]), .RDATA(rdata[0]), .RRESP(rresp[0]), .RLAST(rlast[0]),
    .RVALID(rvalid[0]), .RREADY(rready[0]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data));

  inst_mem_responder #(.DEPTH_LOG2(10), .LATENCY(0), .BEATS(2)) u1 (
    .clk(clk), .resetn(resetn), .ARADDR(araddr[1]), .ARVALID(arvalid[1]),
    .ARREADY(arready[1]), .RDATA(rdata[1]), .RRESP(rresp[1]), .RLAST(rlast[1]),
    .RVALID(rvalid[1]), .RREADY(rready[1]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data));

  inst_mem_responder #(.DEPTH_LOG2(10), .LATENCY(1), .BEATS(4)) u2 (
    .clk(clk), .resetn(resetn), .ARADDR(araddr[2]), .ARVALID(arvalid[2]),
    .ARREADY(arready[2]), .RDATA(rdata[2]), .RRESP(rresp[2]), .RLAST(rlast[2]),
    .RVALID(rvalid[2]), .RREADY(rready[2]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [127:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // u2 burst (LATENCY 1, 4 beats); err selects the out-of-range expectation.
  task automatic burst_u2(input logic [31:0] a, input logic err, input string tag);
    araddr[2]  = a;
    arvalid[2] = 1'b1;
    tick();
    arvalid[2] = 1'b0;
    chk({tag, "_wait_rvalid"}, rvalid[2], 1'b0);
    chk({tag, "_wait_arready"}, arready[2], 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("%s_b%0d_rvalid", tag, k), rvalid[2], 1'b1);
      chk($sformatf("%s_b%0d_rdata", tag, k), rdata[2], err ? 128'h0 : wrapv[k]);
      chk($sformatf("%s_b%0d_rresp", tag, k), rresp[2], err ? 2'b10 : 2'b00);
      chk($sformatf("%s_b%0d_rlast", tag, k), rlast[2], (k == 3) ? 1'b1 : 1'b0);
    end
    tick();
    chk({tag, "_end_rvalid"}, rvalid[2], 1'b0);
    chk({tag, "_end_arready"}, arready[2], 1'b1);
  endtask

  initial begin
    resetn  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < 3; i++) begin
      araddr[i]  = '0;
      arvalid[i] = 1'b0;
      rready[i]  = 1'b1;
    end
    wrapv[0] = 128'hC0C0C0C0_000003FE_10000000_AAAA0000;
    wrapv[1] = 128'hC1C1C1C1_000003FF_10000001_AAAA0001;
    wrapv[2] = 128'hC2C2C2C2_00000000_10000002_AAAA0002;
    wrapv[3] = 128'hC3C3C3C3_00000001_10000003_AAAA0003;
    wrapi[0] = 10'd1022;
    wrapi[1] = 10'd1023;
    wrapi[2] = 10'd0;
    wrapi[3] = 10'd1;

    // Reset state
    tick();
    tick();
    chk("rst_arready0", arready[0], 1'b0);
    chk("rst_arready1", arready[1], 1'b0);
    chk("rst_arready2", arready[2], 1'b0);
    chk("rst_rvalid0", rvalid[0], 1'b0);
    chk("rst_rlast0", rlast[0], 1'b0);
    chk("rst_rdata0", rdata[0], 128'h0);
    chk("rst_rresp0", rresp[0], 2'b00);
    resetn = 1'b1;
    tick();
    chk("rel_arready0", arready[0], 1'b1);
    chk("rel_arready2", arready[2], 1'b1);

    // Preload
    wr(10'd5, E5);
    wr(10'd7, E7);
    wr(10'd8, E8);
    for (int k = 0; k < 4; k++) wr(wrapi[k], wrapv[k]);

    // Single beat, LATENCY 2
    araddr[0]  = 32'h50;
    arvalid[0] = 1'b1;
    tick();
    arvalid[0] = 1'b0;
    chk("t1_T0_rvalid", rvalid[0], 1'b0);
    chk("t1_T0_arready", arready[0], 1'b0);
    tick();
    chk("t1_T1_rvalid", rvalid[0], 1'b0);
    tick();
    chk("t1_T2_rvalid", rvalid[0], 1'b1);
    chk("t1_rdata", rdata[0], E5);
    chk("t1_rresp", rresp[0], 2'b00);
    chk("t1_rlast", rlast[0], 1'b1);
    tick();
    chk("t1_end_rvalid", rvalid[0], 1'b0);
    chk("t1_end_arready", arready[0], 1'b1);

    // Two beats, LATENCY 0, ARVALID held through the final handshake
    araddr[1]  = 32'h7C;
    arvalid[1] = 1'b1;
    tick();
    chk("t2_b0_rvalid", rvalid[1], 1'b1);
    chk("t2_b0_rdata", rdata[1], E7);
    chk("t2_b0_rlast", rlast[1], 1'b0);
    chk("t2_b0_arready", arready[1], 1'b0);
    tick();
    chk("t2_b1_rdata", rdata[1], E8);
    chk("t2_b1_rlast", rlast[1], 1'b1);
    tick();
    chk("t2_noaccept_rvalid", rvalid[1], 1'b0);
    chk("t2_noaccept_arready", arready[1], 1'b1);
    tick();
    arvalid[1] = 1'b0;
    chk("t2_again_rvalid", rvalid[1], 1'b1);
    chk("t2_again_rdata", rdata[1], E7);
    tick();
    chk("t2_again_b1_rdata", rdata[1], E8);
    tick();
    chk("t2_again_end_rvalid", rvalid[1], 1'b0);

    // Backpressure on u1
    rready[1]  = 1'b0;
    araddr[1]  = 32'h70;
    arvalid[1] = 1'b1;
    tick();
    arvalid[1] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("t3_hold%0d_rvalid", c), rvalid[1], 1'b1);
      chk($sformatf("t3_hold%0d_rdata", c), rdata[1], E7);
      chk($sformatf("t3_hold%0d_rlast", c), rlast[1], 1'b0);
    end
    rready[1] = 1'b1;
    tick();
    rready[1] = 1'b0;
    chk("t3_xfer_rdata", rdata[1], E8);
    chk("t3_xfer_rlast", rlast[1], 1'b1);
    tick();
    chk("t3_hold_last_rvalid", rvalid[1], 1'b1);
    chk("t3_hold_last_rdata", rdata[1], E8);
    rready[1] = 1'b1;
    tick();
    chk("t3_end_rvalid", rvalid[1], 1'b0);

    // Out of range, then wrap at the top of the array
    burst_u2(32'h0001_0000, 1'b1, "t4_oor");
    burst_u2(32'h0000_3FE0, 1'b0, "t5_wrap");

    // Reset while in WAIT
    araddr[0]  = 32'h50;
    arvalid[0] = 1'b1;
    tick();
    arvalid[0] = 1'b0;
    resetn = 1'b0;
    #1;
    chk("t6w_rvalid", rvalid[0], 1'b0);
    chk("t6w_arready", arready[0], 1'b0);
    tick();
    tick();
    chk("t6w_held_rvalid", rvalid[0], 1'b0);
    chk("t6w_held_arready", arready[0], 1'b0);
    resetn = 1'b1;
    tick();
    chk("t6w_rel_arready", arready[0], 1'b1);
    chk("t6w_rel_rvalid", rvalid[0], 1'b0);

    // Reset while in DATA
    araddr[2]  = 32'h3FE0;
    arvalid[2] = 1'b1;
    tick();
    arvalid[2] = 1'b0;
    tick();
    chk("t6d_pre_rvalid", rvalid[2], 1'b1);
    resetn = 1'b0;
    #1;
    chk("t6d_rvalid", rvalid[2], 1'b0);
    chk("t6d_rdata", rdata[2], 128'h0);
    chk("t6d_rlast", rlast[2], 1'b0);
    chk("t6d_arready", arready[2], 1'b0);
    tick();
    chk("t6d_held_rvalid", rvalid[2], 1'b0);
    chk("t6d_held_arready", arready[2], 1'b0);
    resetn = 1'b1;
    tick();
    chk("t6d_rel_arready", arready[2], 1'b1);
    chk("t6d_rel_rvalid", rvalid[2], 1'b0);
    burst_u2(32'h0000_3FE0, 1'b0, "t6_post");

    // u0 after reset still returns entry 5
    araddr[0]  = 32'h50;
    arvalid[0] = 1'b1;
    tick();
    arvalid[0] = 1'b0;
    tick();
    tick();
    chk("t6_post_u0_rvalid", rvalid[0], 1'b1);
    chk("t6_post_u0_rdata", rdata[0], E5);
    tick();

    // Write during WAIT to the pending entry is visible in the beat
    araddr[0]  = 32'h50;
    arvalid[0] = 1'b1;
    tick();
    arvalid[0] = 1'b0;
    wr(10'd5, E5N);
    tick();
    chk("t7_rvalid", rvalid[0], 1'b1);
    chk("t7_rdata", rdata[0], E5N);
    tick();
    chk("t7_end_rvalid", rvalid[0], 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
